// File: rtl/stall_control_unit_pkg.sv
// Shared definitions for the stall control unit.
// Holds the RV32 opcode constants the hazard logic decodes, the FSM state
// encoding, and the default divider latency.
package stall_control_unit_pkg;

    localparam int unsigned DEFAULT_DIV_LATENCY = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic {
        StIdle    = 1'b0,
        StDivWait = 1'b1
    } state_e;

endpackage

// File: rtl/reg_use_decoder.sv
// Register-use decoder.
// Tells the hazard logic which source fields of the ID instruction are real
// register reads, so immediate bits sitting in the rs2 slot never cause stalls.
// Ports:
//   i_opcode   - opcode of the instruction in ID
//   o_uses_rs1 - instruction reads rs1
//   o_uses_rs2 - instruction reads rs2
module reg_use_decoder
    import stall_control_unit_pkg::*;
(
    input  logic [6:0] i_opcode,
    output logic       o_uses_rs1,
    output logic       o_uses_rs2
);

    always_comb begin
        o_uses_rs1 = 1'b0;
        o_uses_rs2 = 1'b0;
        case (i_opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: begin
                o_uses_rs1 = 1'b1;
            end
            OPC_STORE, OPC_BRANCH, OPC_OP: begin
                o_uses_rs1 = 1'b1;
                o_uses_rs2 = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/stall_control_unit.sv
// Pipeline stall / flush controller for a 5-stage RV32 core.
// Resolves load-use hazards, multi-cycle divides, taken branches/jumps and
// data-memory wait states into per-register stall, flush and bubble controls,
// and counts cycles in which the PC was held.
// Ports:
//   CLK, RESET                - clock, async active-low reset
//   ID_ADDR1/2, ID_OPCODE     - rs1/rs2/opcode of the ID instruction
//   EXE_ADDR, EXE_MEMREAD     - rd of the EX instruction, EX is a load
//   EXE_DIV                   - EX instruction is DIV/DIVU/REM/REMU
//   BJ_TAKEN                  - branch/jump resolved taken in EX
//   DMEM_BUSY                 - data memory access not yet complete
//   CLR_STATS                 - synchronous clear of STALL_CYCLES
//   *_STALL                   - hold the named pipeline register
//   IF_ID_FLUSH, ID_EX_FLUSH  - load a NOP into IF/ID, ID/EX
//   EX_MEM_BUBBLE             - load a NOP into EX/MEM
//   DIV_DONE                  - divide result valid in EX this cycle
//   STALL_CYCLES              - saturating count of PC-stall cycles
module stall_control_unit
    import stall_control_unit_pkg::*;
#(
    parameter int unsigned DIV_LATENCY = DEFAULT_DIV_LATENCY
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ID_ADDR1,
    input  logic [4:0]  ID_ADDR2,
    input  logic [6:0]  ID_OPCODE,
    input  logic [4:0]  EXE_ADDR,
    input  logic        EXE_MEMREAD,
    input  logic        EXE_DIV,
    input  logic        BJ_TAKEN,
    input  logic        DMEM_BUSY,
    input  logic        CLR_STATS,
    output logic        PC_STALL,
    output logic        IF_ID_STALL,
    output logic        ID_EX_STALL,
    output logic        EX_MEM_STALL,
    output logic        MEM_WB_STALL,
    output logic        IF_ID_FLUSH,
    output logic        ID_EX_FLUSH,
    output logic        EX_MEM_BUBBLE,
    output logic        DIV_DONE,
    output logic [15:0] STALL_CYCLES
);

    // Counter load on divide start: the start cycle and the final (done)
    // cycle are not counted, hence -2.
    localparam logic [5:0] LP_DIV_LOAD = (DIV_LATENCY > 1) ? 6'(DIV_LATENCY - 2) : 6'd0;
    localparam logic       LP_DIV_MULTI = (DIV_LATENCY > 1);

    state_e      r_state;
    logic [5:0]  r_div_cnt;
    logic [15:0] r_stall_cycles;

    logic w_uses_rs1;
    logic w_uses_rs2;
    logic w_src_hit;
    logic w_load_use;
    logic w_div_start;
    logic w_div_hold;
    logic w_div_stall;
    logic w_div_done;
    logic w_pc_stall;

    reg_use_decoder u_reg_use_decoder (
        .i_opcode   (ID_OPCODE),
        .o_uses_rs1 (w_uses_rs1),
        .o_uses_rs2 (w_uses_rs2)
    );

    always_comb begin
        w_src_hit = (w_uses_rs1 && (ID_ADDR1 == EXE_ADDR)) ||
                    (w_uses_rs2 && (ID_ADDR2 == EXE_ADDR));

        // Taken branch wins over load-use: the dependent instruction is
        // being flushed anyway.
        w_load_use = (r_state == StIdle) && EXE_MEMREAD && (EXE_ADDR != 5'd0) &&
                     w_src_hit && !BJ_TAKEN;

        w_div_start = (r_state == StIdle) && EXE_DIV && LP_DIV_MULTI && !BJ_TAKEN;
        w_div_hold  = (r_state == StDivWait) && (r_div_cnt != 6'd0);
        w_div_stall = w_div_start || w_div_hold;
        w_div_done  = ((r_state == StIdle) && EXE_DIV && !LP_DIV_MULTI) ||
                      ((r_state == StDivWait) && (r_div_cnt == 6'd0));

        w_pc_stall = DMEM_BUSY || w_div_stall || w_load_use;
    end

    // Memory wait outranks everything; flushes/bubbles are suppressed so the
    // pending action is applied when DMEM_BUSY drops. All controls are gated
    // by RESET so nothing fires while the core is held in reset.
    always_comb begin
        PC_STALL      = RESET && w_pc_stall;
        IF_ID_STALL   = RESET && w_pc_stall;
        ID_EX_STALL   = RESET && (DMEM_BUSY || w_div_stall);
        EX_MEM_STALL  = RESET && DMEM_BUSY;
        MEM_WB_STALL  = RESET && DMEM_BUSY;
        IF_ID_FLUSH   = RESET && !DMEM_BUSY && BJ_TAKEN;
        ID_EX_FLUSH   = RESET && !DMEM_BUSY && (BJ_TAKEN || w_load_use);
        EX_MEM_BUBBLE = RESET && !DMEM_BUSY && w_div_stall;
        DIV_DONE      = RESET && !DMEM_BUSY && w_div_done;
    end

    assign STALL_CYCLES = r_stall_cycles;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state        <= StIdle;
            r_div_cnt      <= 6'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (CLR_STATS) begin
                r_stall_cycles <= 16'd0;
            end else if (w_pc_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end

            if (!DMEM_BUSY) begin
                case (r_state)
                    StIdle: begin
                        if (w_div_start) begin
                            r_state   <= StDivWait;
                            r_div_cnt <= LP_DIV_LOAD;
                        end
                    end
                    StDivWait: begin
                        if (r_div_cnt != 6'd0) begin
                            r_div_cnt <= r_div_cnt - 6'd1;
                        end else begin
                            r_state <= StIdle;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_stall_control_unit.sv
module tb_stall_control_unit;
    import stall_control_unit_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [4:0]  ID_ADDR1, ID_ADDR2, EXE_ADDR;
    logic [6:0]  ID_OPCODE;
    logic        EXE_MEMREAD, EXE_DIV, BJ_TAKEN, DMEM_BUSY, CLR_STATS;
    logic        PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL;
    logic        IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE, DIV_DONE;
    logic [15:0] STALL_CYCLES;

    int tests_run = 0;
    int fails     = 0;
    logic [8:0] got;

    // Output vector bit order: PC IFID IDEX EXMEM MEMWB | IFF IDF BUB DONE
    localparam logic [8:0] V_NONE  = 9'b00000_0000;
    localparam logic [8:0] V_LU    = 9'b11000_0100;
    localparam logic [8:0] V_DIV   = 9'b11100_0010;
    localparam logic [8:0] V_DONE  = 9'b00000_0001;
    localparam logic [8:0] V_BUSY  = 9'b11111_0000;
    localparam logic [8:0] V_FLUSH = 9'b00000_1100;

    stall_control_unit #(.DIV_LATENCY(4)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .ID_ADDR1      (ID_ADDR1),
        .ID_ADDR2      (ID_ADDR2),
        .ID_OPCODE     (ID_OPCODE),
        .EXE_ADDR      (EXE_ADDR),
        .EXE_MEMREAD   (EXE_MEMREAD),
        .EXE_DIV       (EXE_DIV),
        .BJ_TAKEN      (BJ_TAKEN),
        .DMEM_BUSY     (DMEM_BUSY),
        .CLR_STATS     (CLR_STATS),
        .PC_STALL      (PC_STALL),
        .IF_ID_STALL   (IF_ID_STALL),
        .ID_EX_STALL   (ID_EX_STALL),
        .EX_MEM_STALL  (EX_MEM_STALL),
        .MEM_WB_STALL  (MEM_WB_STALL),
        .IF_ID_FLUSH   (IF_ID_FLUSH),
        .ID_EX_FLUSH   (ID_EX_FLUSH),
        .EX_MEM_BUBBLE (EX_MEM_BUBBLE),
        .DIV_DONE      (DIV_DONE),
        .STALL_CYCLES  (STALL_CYCLES)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] outs();
        return {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_STALL,
                IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_BUBBLE, DIV_DONE};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        ID_ADDR1 = 5'd0; ID_ADDR2 = 5'd0; ID_OPCODE = 7'd0; EXE_ADDR = 5'd0;
        EXE_MEMREAD = 1'b0; EXE_DIV = 1'b0; BJ_TAKEN = 1'b0;
        DMEM_BUSY = 1'b0; CLR_STATS = 1'b0;
    endtask

    // Set up EX = lw x<rd>, ID = <opc> with rs1/rs2 fields, then settle.
    task automatic set_lu(input logic [4:0] rd, input logic [6:0] opc,
                          input logic [4:0] a1, input logic [4:0] a2);
        EXE_MEMREAD = 1'b1; EXE_ADDR = rd; ID_OPCODE = opc; ID_ADDR1 = a1; ID_ADDR2 = a2;
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        // Hostile inputs: everything that would otherwise assert an output.
        EXE_MEMREAD = 1'b1; EXE_ADDR = 5'd5; ID_OPCODE = OPC_OP; ID_ADDR1 = 5'd5;
        EXE_DIV = 1'b1; BJ_TAKEN = 1'b1; DMEM_BUSY = 1'b1; CLR_STATS = 1'b0;
        step();
        got = outs();
        tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL reset_outputs: got %b want %b", got, V_NONE);
        end
        tests_run++;
        if (STALL_CYCLES !== 16'd0) begin
            fails++; $display("FAIL reset_count: got %h want 0000", STALL_CYCLES);
        end
        quiet();
        step();
        RESET = 1'b1;
        step();
        got = outs();
        tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL idle_after_reset: got %b want %b", got, V_NONE);
        end
    endtask

    task automatic test_load_use();
        quiet();
        set_lu(5'd5, OPC_OP, 5'd5, 5'd7);           // add x6,x5,x7
        got = outs();
        tests_run++;
        if (got !== V_LU) begin
            fails++; $display("FAIL lu_rs1: got %b want %b", got, V_LU);
        end
        step();
        EXE_MEMREAD = 1'b0; EXE_ADDR = 5'd0; #1;      // bubble now in EX
        got = outs();
        tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL lu_one_cycle: got %b want %b", got, V_NONE);
        end
        set_lu(5'd0, OPC_OP, 5'd0, 5'd7);           // rd = x0
        got = outs();
        tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL lu_x0: got %b want %b", got, V_NONE);
        end
        set_lu(5'd5, OPC_OP, 5'd7, 5'd5);           // add x6,x7,x5
        got = outs();
        tests_run++;
        if (got !== V_LU) begin
            fails++; $display("FAIL lu_rs2_op: got %b want %b", got, V_LU);
        end
        quiet(); step();
    endtask

    task automatic test_reg_use();
        quiet();
        set_lu(5'd5, OPC_STORE, 5'd2, 5'd5);        // sw x5,0(x2)
        got = outs(); tests_run++;
        if (got !== V_LU) begin
            fails++; $display("FAIL store_rs2: got %b want %b", got, V_LU);
        end
        set_lu(5'd5, OPC_OP_IMM, 5'd2, 5'd5);       // addi, imm bits = 5
        got = outs(); tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL addi_rs2_ignored: got %b want %b", got, V_NONE);
        end
        set_lu(5'd5, OPC_BRANCH, 5'd1, 5'd5);
        got = outs(); tests_run++;
        if (got !== V_LU) begin
            fails++; $display("FAIL branch_rs2: got %b want %b", got, V_LU);
        end
        set_lu(5'd5, OPC_JALR, 5'd5, 5'd0);
        got = outs(); tests_run++;
        if (got !== V_LU) begin
            fails++; $display("FAIL jalr_rs1: got %b want %b", got, V_LU);
        end
        set_lu(5'd5, OPC_LOAD, 5'd3, 5'd5);         // load, rs2 field unused
        got = outs(); tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL load_rs2_ignored: got %b want %b", got, V_NONE);
        end
        set_lu(5'd5, 7'b0110111, 5'd5, 5'd5);       // LUI reads nothing
        got = outs(); tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL lui_no_use: got %b want %b", got, V_NONE);
        end
        quiet(); step();
    endtask

    task automatic test_divide();
        quiet();
        CLR_STATS = 1'b1; step(); CLR_STATS = 1'b0; #1;
        tests_run++;
        if (STALL_CYCLES !== 16'd0) begin
            fails++; $display("FAIL div_clear: got %h want 0000", STALL_CYCLES);
        end
        EXE_DIV = 1'b1; #1;
        for (int i = 0; i < 3; i++) begin
            got = outs(); tests_run++;
            if (got !== V_DIV) begin
                fails++; $display("FAIL div_stall_%0d: got %b want %b", i, got, V_DIV);
            end
            step();
        end
        got = outs(); tests_run++;
        if (got !== V_DONE) begin
            fails++; $display("FAIL div_done: got %b want %b", got, V_DONE);
        end
        step();
        EXE_DIV = 1'b0; #1;
        got = outs(); tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL div_after: got %b want %b", got, V_NONE);
        end
        tests_run++;
        if (STALL_CYCLES !== 16'd3) begin
            fails++; $display("FAIL div_count: got %0d want 3", STALL_CYCLES);
        end
    endtask

    task automatic test_dmem_busy_div();
        quiet();
        EXE_DIV = 1'b1;
        step(); step();                              // start + first wait cycle
        DMEM_BUSY = 1'b1; #1;
        for (int i = 0; i < 2; i++) begin
            got = outs(); tests_run++;
            if (got !== V_BUSY) begin
                fails++; $display("FAIL busy_div_%0d: got %b want %b", i, got, V_BUSY);
            end
            tests_run++;
            if (dut.r_div_cnt !== 6'd1) begin
                fails++; $display("FAIL busy_cnt_frozen_%0d: got %0d want 1", i, dut.r_div_cnt);
            end
            step();
        end
        DMEM_BUSY = 1'b0; #1;
        got = outs(); tests_run++;
        if (got !== V_DIV) begin
            fails++; $display("FAIL busy_resume: got %b want %b", got, V_DIV);
        end
        step();
        got = outs(); tests_run++;
        if (got !== V_DONE) begin
            fails++; $display("FAIL busy_div_done: got %b want %b", got, V_DONE);
        end
        step();
        quiet(); #1;
    endtask

    task automatic test_branch();
        quiet();
        BJ_TAKEN = 1'b1;
        set_lu(5'd5, OPC_OP, 5'd5, 5'd7);
        got = outs(); tests_run++;
        if (got !== V_FLUSH) begin
            fails++; $display("FAIL bj_over_lu: got %b want %b", got, V_FLUSH);
        end
        DMEM_BUSY = 1'b1; #1;
        got = outs(); tests_run++;
        if (got !== V_BUSY) begin
            fails++; $display("FAIL busy_over_bj: got %b want %b", got, V_BUSY);
        end
        step();
        DMEM_BUSY = 1'b0; #1;
        got = outs(); tests_run++;
        if (got !== V_FLUSH) begin
            fails++; $display("FAIL bj_after_busy: got %b want %b", got, V_FLUSH);
        end
        BJ_TAKEN = 1'b0; DMEM_BUSY = 1'b1; #1;
        step();
        DMEM_BUSY = 1'b0; #1;
        got = outs(); tests_run++;
        if (got !== V_LU) begin
            fails++; $display("FAIL lu_after_busy: got %b want %b", got, V_LU);
        end
        quiet(); step();
    endtask

    task automatic test_reset_mid_div();
        quiet();
        EXE_DIV = 1'b1;
        step(); step();
        RESET = 1'b0; #1;
        got = outs(); tests_run++;
        if (got !== V_NONE) begin
            fails++; $display("FAIL rst_div_outputs: got %b want %b", got, V_NONE);
        end
        tests_run++;
        if (dut.r_state !== StIdle) begin
            fails++; $display("FAIL rst_div_state: got %0d want %0d", dut.r_state, StIdle);
        end
        step();
        RESET = 1'b1; #1;
        // EXE_DIV still high: a fresh divide starts from IDLE.
        for (int i = 0; i < 3; i++) begin
            got = outs(); tests_run++;
            if (got !== V_DIV) begin
                fails++; $display("FAIL rst_redo_stall_%0d: got %b want %b", i, got, V_DIV);
            end
            step();
        end
        got = outs(); tests_run++;
        if (got !== V_DONE) begin
            fails++; $display("FAIL rst_redo_done: got %b want %b", got, V_DONE);
        end
        step();
        quiet(); #1;
    endtask

    task automatic test_saturation();
        quiet();
        CLR_STATS = 1'b1; step(); CLR_STATS = 1'b0;
        DMEM_BUSY = 1'b1;
        repeat (65534) step();
        tests_run++;
        if (STALL_CYCLES !== 16'hFFFE) begin
            fails++; $display("FAIL sat_fffe: got %h want fffe", STALL_CYCLES);
        end
        step();
        tests_run++;
        if (STALL_CYCLES !== 16'hFFFF) begin
            fails++; $display("FAIL sat_ffff: got %h want ffff", STALL_CYCLES);
        end
        repeat (3) step();
        tests_run++;
        if (STALL_CYCLES !== 16'hFFFF) begin
            fails++; $display("FAIL sat_hold: got %h want ffff", STALL_CYCLES);
        end
        CLR_STATS = 1'b1;                            // still stalling
        step();
        tests_run++;
        if (STALL_CYCLES !== 16'd0) begin
            fails++; $display("FAIL clr_priority: got %h want 0000", STALL_CYCLES);
        end
        quiet(); step();
    endtask

    initial begin
        quiet();
        RESET = 1'b0;
        test_reset();
        test_load_use();
        test_reg_use();
        test_divide();
        test_dmem_busy_div();
        test_branch();
        test_reset_mid_div();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
